// File: rtl/shl_pkg.sv
// Shared types and helpers for the pipelined left barrel shifter.
// A stage record carries one beat plus the control bits later stages still need.
package shl_pkg;

  localparam int SHL_WIDTH = 8;
  localparam int SHL_SHW   = 3;

  typedef struct packed {
    logic                 valid;
    logic [SHL_WIDTH-1:0] data;
    logic [SHL_SHW-1:0]   shamt;
    logic                 rot;
  } stage_t;

  // Left shift or rotate by a constant amount. The upper half of {data, data}
  // shifted left is exactly the rotated word.
  function automatic logic [SHL_WIDTH-1:0] shl_step(input logic [SHL_WIDTH-1:0] data,
                                                    input int unsigned          amt,
                                                    input logic                 rot);
    logic [2*SHL_WIDTH-1:0] wide;
    wide = {data, data} << amt;
    return rot ? wide[2*SHL_WIDTH-1 -: SHL_WIDTH] : (data << amt);
  endfunction

endpackage

// File: rtl/shl_stage.sv
// One registered barrel-shifter stage: shifts by AMT when shamt[BIT] is set,
// with a valid/ready pipeline register that loads when empty or draining.
module shl_stage
  import shl_pkg::*;
#(
  parameter int unsigned AMT = 1,
  parameter int          BIT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 up_valid,
  input  logic [SHL_WIDTH-1:0] up_data,
  input  logic [SHL_SHW-1:0]   up_shamt,
  input  logic                 up_rot,
  output logic                 up_ready,
  output logic                 dn_valid,
  output logic [SHL_WIDTH-1:0] dn_data,
  output logic [SHL_SHW-1:0]   dn_shamt,
  output logic                 dn_rot,
  input  logic                 dn_ready
);

  stage_t r;

  // A full stage that drains this cycle can take the next beat at once.
  assign up_ready = !r.valid || dn_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: data/shamt/rot are cleared too, not just valid, so out_data reads
      // 0x00 after reset instead of a stale beat.
      r <= '0;
    end else if (up_ready) begin
      // NOTE: non-blocking assignments here so every stage samples the value its
      // upstream neighbour held before this edge, independent of block ordering.
      r.valid <= up_valid;
      r.data  <= up_shamt[BIT] ? shl_step(up_data, AMT, up_rot) : up_data;
      r.shamt <= up_shamt;
      r.rot   <= up_rot;
    end
  end

  assign dn_valid = r.valid;
  assign dn_data  = r.data;
  assign dn_shamt = r.shamt;
  assign dn_rot   = r.rot;

endmodule

// File: rtl/shl_barrel_pipe.sv
// 8-bit left barrel shifter (logical or rotate), three stages shifting by 1, 2, 4,
// with valid/ready on both sides; in_ready is combinational from out_ready.
module shl_barrel_pipe
  import shl_pkg::*;
#(
  parameter int WIDTH = SHL_WIDTH,
  parameter int SHW   = SHL_SHW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_rot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // pipe[k] is the register of stage k; rdy[k-1] is the ready into stage k,
  // and rdy[3] is the downstream ready.
  stage_t     pipe [1:3];
  logic [3:0] rdy;

  assign rdy[3] = out_ready;

  shl_stage #(.AMT(1), .BIT(0)) u_s1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (in_valid),
    .up_data  (in_data),
    .up_shamt (in_shamt),
    .up_rot   (in_rot),
    .up_ready (rdy[0]),
    .dn_valid (pipe[1].valid),
    .dn_data  (pipe[1].data),
    .dn_shamt (pipe[1].shamt),
    .dn_rot   (pipe[1].rot),
    .dn_ready (rdy[1])
  );

  shl_stage #(.AMT(2), .BIT(1)) u_s2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (pipe[1].valid),
    .up_data  (pipe[1].data),
    .up_shamt (pipe[1].shamt),
    .up_rot   (pipe[1].rot),
    .up_ready (rdy[1]),
    .dn_valid (pipe[2].valid),
    .dn_data  (pipe[2].data),
    .dn_shamt (pipe[2].shamt),
    .dn_rot   (pipe[2].rot),
    .dn_ready (rdy[2])
  );

  shl_stage #(.AMT(4), .BIT(2)) u_s3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (pipe[2].valid),
    .up_data  (pipe[2].data),
    .up_shamt (pipe[2].shamt),
    .up_rot   (pipe[2].rot),
    .up_ready (rdy[2]),
    .dn_valid (pipe[3].valid),
    .dn_data  (pipe[3].data),
    .dn_shamt (pipe[3].shamt),
    .dn_rot   (pipe[3].rot),
    .dn_ready (rdy[3])
  );

  assign in_ready  = rdy[0];
  assign out_valid = pipe[3].valid;
  assign out_data  = pipe[3].data;

endmodule

// File: tb/tb_shl_barrel_pipe.sv
// Self-checking bench for shl_barrel_pipe: arithmetic reference model with an
// in-order scoreboard, plus directed latency, backpressure and reset scenarios.
module tb_shl_barrel_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic [2:0] in_shamt = 3'd0;
  logic       in_rot = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;

  int tests = 0;
  int fails = 0;

  logic [7:0] sb [$];
  int         rx_count = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  logic [7:0] got [5];
  int         acc;
  int         n;
  int         budget;
  int         base;
  int         sent;
  int         seen;

  shl_barrel_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_rot    (in_rot),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference: shift the value as an integer, optionally OR in the bits that
  // fell off the top, keep the low 8 bits.
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input int s, input logic r);
    int v;
    v = int'(d) << s;
    if (r) v = v | (int'(d) >> (8 - s));
    return v[7:0];
  endfunction

  // Scoreboard and stall-stability checker, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_data_held", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got 0x%0h, expected no beat", out_data);
        end else begin
          check("stream_data", out_data, sb.pop_front());
          rx_count++;
        end
      end
      if (in_valid && in_ready) sb.push_back(ref_shift(in_data, int'(in_shamt), in_rot));
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic [7:0] d, input logic [2:0] s, input logic r, input logic [7:0] exp);
    in_data  = d;
    in_shamt = s;
    in_rot   = r;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("latency_valid_%02h_%0d_%0d_c%0d", d, s, r, k), out_valid, (k == 3));
      if (k == 3) check($sformatf("result_%02h_%0d_%0d", d, s, r), out_data, exp);
      next_cycle();
      in_valid = 1'b0;
    end
  endtask

  initial begin
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 8'h00);
    check("reset_in_ready", in_ready, 1);
    next_cycle();

    check("model_shl_b5_3", ref_shift(8'hB5, 3, 1'b0), 8'hA8);
    check("model_rol_b5_3", ref_shift(8'hB5, 3, 1'b1), 8'hAD);
    check("model_rol_81_7", ref_shift(8'h81, 7, 1'b1), 8'hC0);
    check("model_shl_81_7", ref_shift(8'h81, 7, 1'b0), 8'h80);

    run_one(8'hB5, 3'd3, 1'b0, 8'hA8);
    run_one(8'hB5, 3'd3, 1'b1, 8'hAD);
    run_one(8'h81, 3'd7, 1'b1, 8'hC0);
    run_one(8'h81, 3'd7, 1'b0, 8'h80);
    run_one(8'h5A, 3'd0, 1'b1, 8'h5A);
    run_one(8'h5A, 3'd0, 1'b0, 8'h5A);

    // Every data/shamt/rot combination back-to-back.
    for (int idx = 0; idx < 4096 + 3; idx++) begin
      if (idx < 4096) begin
        in_valid = 1'b1;
        in_data  = 8'(idx);
        in_shamt = 3'(idx >> 8);
        in_rot   = 1'(idx >> 11);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (idx < 4096) check("stream_in_ready", in_ready, 1);
      if (idx >= 3) check("stream_no_gap", out_valid, 1);
      next_cycle();
    end
    repeat (3) next_cycle();

    // Backpressure: five beats offered against a blocked output.
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_data  = 8'(acc + 1);
      in_shamt = 3'd1;
      in_rot   = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      next_cycle();
    end
    in_data = 8'(acc + 1);
    @(negedge clk);
    check("bp_accepted", acc, 3);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_hold_data", out_data, 8'h02);
    next_cycle();
    out_ready = 1'b1;
    n = 0;
    budget = 0;
    while (n < 5 && budget < 40) begin
      in_valid = (acc < 5);
      in_data  = 8'(acc + 1);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      if (out_valid && out_ready) begin
        got[n] = out_data;
        n++;
      end
      next_cycle();
      budget++;
    end
    in_valid = 1'b0;
    check("bp_out_count", n, 5);
    for (int i = 0; i < 5; i++) check($sformatf("bp_order_%0d", i), got[i], 8'(2 * (i + 1)));
    repeat (4) next_cycle();

    // Random valid/ready toggling.
    base = rx_count;
    sent = 0;
    budget = 0;
    while ((sent < 10000 || rx_count - base < 10000) && budget < 40000) begin
      in_valid  = (sent < 10000) && ($urandom_range(0, 9) < 7);
      in_data   = 8'($urandom);
      in_shamt  = 3'($urandom_range(0, 7));
      in_rot    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      next_cycle();
      budget++;
    end
    in_valid = 1'b0;
    check("rand_sent", sent, 10000);
    check("rand_received", rx_count - base, 10000);
    check("rand_sb_empty", sb.size(), 0);

    // Reset with three beats stalled in flight.
    out_ready = 1'b1;
    repeat (5) next_cycle();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hC1 + k);
      in_shamt = 3'(k + 1);
      in_rot   = 1'b1;
      next_cycle();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("pre_reset_full", out_valid, 1);
    check("pre_reset_in_ready", in_ready, 0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_out_valid", out_valid, 0);
    check("post_reset_out_data", out_data, 8'h00);
    check("post_reset_in_ready", in_ready, 1);
    next_cycle();
    out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
      next_cycle();
    end
    check("flushed_beats_gone", seen, 0);
    check("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shl_barrel_pipe.md
Name: shl_barrel_pipe

Overview:
- 8-bit left barrel shifter: logical shift-left or rotate-left by 0..7 positions.
- Pipelined as three registered stages that shift by 1, 2 and 4 in turn.
- Valid/ready handshake on both input and output, so it can sit in a streaming datapath with backpressure.
- Counterpart of the team's combinational right-shift datapath: left direction, with buffering and flow control.

Parameters:
- WIDTH, 8, data width; must be a power of two, and only 8 is verified.
- SHW, 3, shift-amount width (log2 WIDTH).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept the input beat this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHW  shift amount.
- in_rot  in  1  1 = rotate-left, 0 = logical shift-left (zero fill from bit 0).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  shifted result.

Behaviour:
- Reset: one clock and a synchronous, active-low reset (rst_n) are already decided.
  - On a clk edge with rst_n=0, every stage valid clears and every stage data/shamt/rot register clears to 0.
  - Result after reset: out_valid=0, out_data=0x00, in_ready=1 from the first cycle after reset release.
- Transfers:
  - Input transfer occurs when in_valid && in_ready at the clk edge.
  - Output transfer occurs when out_valid && out_ready.
- Stage S1 (shift by 1), registered:
  - d1 = in_shamt[0] ? shl1(in_data) : in_data.
  - S1 also carries shamt[2:1] and rot forward.
- Stage S2: shifts by 2 when shamt[1] is set; carries shamt[2] and rot.
- Stage S3: shifts by 4 when shamt[2] is set; drives out_data and out_valid.
- Shift rules:
  - Logical: bits shifted past the MSB are discarded; zeros enter at the LSB.
  - Rotate: bits shifted past the MSB re-enter at the LSB.
  - shamt=0 passes data through unchanged.
- Latency and throughput:
  - Latency is exactly 3 cycles from input transfer to out_valid, with no stalls.
  - Throughput is 1 beat per cycle.
- Flow control:
  - Stage k loads when it is empty or when its contents move downstream in the same cycle: ready_k = !v_k || ready_(k+1), with ready_4 = out_ready.
  - in_ready = ready_1. This is a combinational path from out_ready to in_ready; it is intentional, with no skid buffer.
  - A stalled stage holds its data, shamt, rot and valid unchanged.
  - A bubble (valid=0) upstream of a stall collapses, so a full stall holds at most 3 beats.
- Data integrity:
  - Beats leave in order; none is lost or duplicated.
  - out_data is stable while out_valid && !out_ready.
- Simultaneous events:
  - A stage that is full and drains in the same cycle takes the new upstream beat in that cycle.
  - A stage with v_k=0 that does not load keeps v_k=0 and its data is don't-care. Registers are still cleared by reset.
- Reset during operation: all in-flight beats are discarded, out_valid drops on the next edge, and no partial result appears.
- Inputs are sampled only on transfer. in_data, in_shamt and in_rot may change freely when in_valid=0.

Decomposition:
- Package shl_pkg holds:
  - the WIDTH/SHW constants;
  - a stage record typedef {valid, data[WIDTH-1:0], shamt[SHW-1:0], rot};
  - a function shl_step(data, amt, rot) returning the left shift or rotate by a constant amount.
- One natural sub-module, shl_stage:
  - parameter AMT (1, 2, 4), the shamt bit index, and the shared handshake logic;
  - instantiated three times by shl_barrel_pipe.

Test Plan:
- Logical shift: in_data=0xB5, shamt=3, rot=0, out_ready=1 -> out_data=0xA8 exactly 3 cycles later, out_valid for one cycle.
- Rotate and pass-through:
  - 0xB5, shamt=3, rot=1 -> 0xAD.
  - 0x81, shamt=7, rot=1 -> 0xC0.
  - 0x81, shamt=7, rot=0 -> 0x80.
  - shamt=0 -> unchanged.
- Exhaustive stream: all 256 data × 8 shamt × 2 rot back-to-back with out_ready=1 -> one result per cycle matching the reference model; no gaps after the 3-cycle fill.
- Backpressure: hold out_ready=0 and offer 5 beats (0x01, 0x02, 0x03, 0x04, 0x05, shamt=1, rot=0) -> in_ready drops after 3 accepted; out_data holds 0x02. Release out_ready -> outputs 0x02, 0x04, 0x06, 0x08, 0x0A in order.
- Random out_ready/in_valid toggling for 10k beats -> scoreboard shows in-order delivery with no loss or duplication, and out_data stable while stalled.
- Reset mid-stream: rst_n=0 for 1 cycle with 3 beats in flight -> out_valid=0 and out_data=0x00 next cycle, in_ready=1, and none of the flushed beats ever appears.
